vault_sequencer: RTL and testbench
==================================

Name: vault_sequencer

Overview:
Top-level controller for the vault's puzzle phases. Each phase checker holds its own step state and reports done/fail until it is reset. This block activates one phase at a time by releasing its reset, and advances to the next phase on done. It also counts failed attempts, enforces a per-phase timeout, and imposes a lockout after too many failures.

Parameters:
NUM_PHASES, 3, number of phase checkers sequenced in order 0..NUM_PHASES-1
MAX_ATTEMPTS, 3, failed attempts allowed before lockout
PHASE_TIMEOUT, 500, cycles allowed in RUN for one phase before it counts as a failure
LOCKOUT_CYCLES, 1000, cycles held in LOCKOUT before attempts are restored

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin an attempt; honoured only in IDLE
relock  in  1  leave OPEN and return to IDLE; ignored elsewhere
phase_done  in  NUM_PHASES  per-phase done, level
phase_fail  in  NUM_PHASES  per-phase fail, level
phase_rst  out  NUM_PHASES  per-phase synchronous-use reset, active-high
active_phase  out  PW=max(1,clog2(NUM_PHASES))  index of the current phase
vault_open  out  1  all phases passed
locked_out  out  1  lockout in progress
fail_pulse  out  1  one-cycle pulse on each failed attempt
attempts_left  out  AW=clog2(MAX_ATTEMPTS+1)  remaining attempts

Behaviour:
- Reset values: state IDLE; phase_rst all 1; active_phase 0; vault_open 0; locked_out 0; fail_pulse 0; attempts_left MAX_ATTEMPTS; timer 0.
- All outputs are registered.
- States: IDLE, ARM, RUN, OPEN, LOCKOUT.
- IDLE:
  - phase_rst is all 1 and active_phase is 0.
  - start=1 moves to ARM with idx=0.
- ARM:
  - Lasts exactly one cycle. phase_rst stays all 1, which flushes the target phase. The timer is cleared.
  - Next state is RUN.
- RUN:
  - phase_rst[idx]=0 and all other bits are 1. The timer increments every cycle.
  - Only bit idx of phase_done/phase_fail is sampled. Bits of other phases are ignored.
  - Failure: phase_fail[idx]=1 or timer==PHASE_TIMEOUT-1.
    - fail_pulse=1 for the next cycle and attempts_left decrements.
    - If the new attempts_left is 0, go to LOCKOUT. Otherwise go to IDLE; a retry needs a new start and restarts from phase 0.
  - Failure has priority over phase_done if both are seen in the same cycle.
  - Success: phase_done[idx]=1 with no failure.
    - If idx==NUM_PHASES-1, go to OPEN.
    - Otherwise idx increments and the state goes to ARM.
- Phase-advance latency: done is seen in RUN at cycle N. At N+1 the state is ARM, active_phase=idx+1 and phase_rst is all 1. At N+2 the state is RUN with phase_rst[idx+1]=0.
- OPEN:
  - vault_open=1 and phase_rst is all 1.
  - relock=1 moves to IDLE, clears vault_open and restores attempts_left to MAX_ATTEMPTS.
  - start is ignored.
- LOCKOUT:
  - locked_out=1 and phase_rst is all 1. start and relock are ignored.
  - The timer counts up to LOCKOUT_CYCLES-1. The state then goes to IDLE, attempts_left is restored to MAX_ATTEMPTS and locked_out clears.
- Counters: one shared timer, width TW=clog2(max(PHASE_TIMEOUT,LOCKOUT_CYCLES)+1). It is cleared on every state entry and saturates, never wraps. attempts_left never underflows.
- start arriving in the same cycle as the return to IDLE is not seen; it must be held or re-pulsed.
- Reset asserted mid-attempt returns everything to the reset values immediately. There is no partial-progress memory.

Decomposition:
- Package vault_pkg holds:
  - typedef vs_state_t {IDLE, ARM, RUN, OPEN, LOCKOUT};
  - localparam defaults for NUM_PHASES and MAX_ATTEMPTS;
  - the direction encoding constants shared with the phase checkers.
- Sub-module vault_timer: up-counter with clear, enable, parameterised terminal value and an expire flag. It is instantiated once and shared by RUN and LOCKOUT.

Test Plan:
Bench overrides PHASE_TIMEOUT=20 and LOCKOUT_CYCLES=16.
- Happy path: start; assert phase_done[0], [1], [2] each 3 cycles after that phase's RUN entry -> active_phase steps 0,1,2 with a one-cycle ARM gap; vault_open=1; attempts_left=3; fail_pulse never asserted.
- Fail then recover: phase_fail[1] in RUN of phase 1 -> fail_pulse one cycle, attempts_left=2, IDLE, active_phase=0; then start and full pass -> vault_open=1.
- Timeout: start, hold all inputs 0 -> fail at RUN cycle 20, attempts_left=2, state IDLE.
- Lockout: three consecutive failures -> locked_out=1 for 16 cycles; start during lockout ignored; then attempts_left=3, IDLE.
- Priority and isolation: phase_done[2]=1 while active_phase=0 -> ignored; phase_done[0] and phase_fail[0] together -> counts as a failure.
- Reset mid-RUN of phase 1 -> next edge all outputs at reset values; relock in OPEN -> IDLE with attempts_left=3.

Source files
------------

// File: rtl/vault_pkg.sv
// Shared types and defaults for the vault sequencer and the phase checkers it drives.
package vault_pkg;

  typedef enum logic [2:0] {IDLE, ARM, RUN, OPEN, LOCKOUT} vs_state_t;

  localparam int DEF_NUM_PHASES   = 3;
  localparam int DEF_MAX_ATTEMPTS = 3;

  // Direction symbols entered into the phase checkers.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

endpackage

// File: rtl/vault_timer.sv
// Shared cycle counter: clears on request, counts while enabled, saturates at all-ones.
module vault_timer #(
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW-1:0] terminal,
  output logic          expire
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != {TW{1'b1}}))
      count <= count + 1'b1;
  end

  assign expire = enable && (count == terminal);

endmodule

// File: rtl/vault_sequencer.sv
// Walks the phase checkers in order, releasing one reset at a time, and tracks
// failed attempts, per-phase timeout and lockout.
module vault_sequencer
  import vault_pkg::*;
#(
  parameter  int NUM_PHASES     = DEF_NUM_PHASES,
  parameter  int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter  int PHASE_TIMEOUT  = 500,
  parameter  int LOCKOUT_CYCLES = 1000,
  localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  localparam int AW = $clog2(MAX_ATTEMPTS + 1),
  localparam int TW = $clog2(((PHASE_TIMEOUT > LOCKOUT_CYCLES) ? PHASE_TIMEOUT : LOCKOUT_CYCLES) + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  relock,
  input  logic [NUM_PHASES-1:0] phase_done,
  input  logic [NUM_PHASES-1:0] phase_fail,
  output logic [NUM_PHASES-1:0] phase_rst,
  output logic [PW-1:0]         active_phase,
  output logic                  vault_open,
  output logic                  locked_out,
  output logic                  fail_pulse,
  output logic [AW-1:0]         attempts_left
);

  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_PHASES - 1);
  localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_ATTEMPTS);
  localparam logic [TW-1:0] RUN_TERM = TW'(PHASE_TIMEOUT - 1);
  localparam logic [TW-1:0] LCK_TERM = TW'(LOCKOUT_CYCLES - 1);

  vs_state_t     state;
  logic          run_fail;
  logic          run_done;
  logic          state_change;
  logic          tmr_enable;
  logic          tmr_expire;
  logic [TW-1:0] tmr_terminal;

  // active_phase doubles as the phase index, so only the live phase's flags are seen.
  // NOTE: every signal gets a value on every path through always_comb; a missing
  // assignment would infer a latch.
  always_comb begin
    run_fail     = (state == RUN) && (phase_fail[active_phase] || tmr_expire);
    run_done     = (state == RUN) && phase_done[active_phase];
    tmr_enable   = (state == RUN) || (state == LOCKOUT);
    tmr_terminal = (state == LOCKOUT) ? LCK_TERM : RUN_TERM;
    state_change = ((state == IDLE) && start) || (state == ARM) || run_fail || run_done ||
                   ((state == OPEN) && relock) || ((state == LOCKOUT) && tmr_expire);
  end

  // Clearing on the transition edge makes the timer read 0 in a state's first cycle.
  vault_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_change),
    .enable   (tmr_enable),
    .terminal (tmr_terminal),
    .expire   (tmr_expire)
  );

  // NOTE: state and outputs use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      phase_rst     <= '1;
      active_phase  <= '0;
      vault_open    <= 1'b0;
      locked_out    <= 1'b0;
      fail_pulse    <= 1'b0;
      attempts_left <= ATT_MAX;
    end else begin
      fail_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= ARM;
            active_phase <= '0;
            phase_rst    <= '1;
          end
        end
        ARM: begin
          state     <= RUN;
          phase_rst <= ~(NUM_PHASES'(1) << active_phase);
        end
        RUN: begin
          // Failure wins over a simultaneous done.
          if (run_fail) begin
            fail_pulse    <= 1'b1;
            phase_rst     <= '1;
            active_phase  <= '0;
            attempts_left <= (attempts_left != '0) ? attempts_left - 1'b1 : '0;
            if (attempts_left <= AW'(1)) begin
              state      <= LOCKOUT;
              locked_out <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (run_done) begin
            phase_rst <= '1;
            if (active_phase == LAST_IDX) begin
              state      <= OPEN;
              vault_open <= 1'b1;
            end else begin
              state        <= ARM;
              active_phase <= active_phase + 1'b1;
            end
          end
        end
        OPEN: begin
          if (relock) begin
            state         <= IDLE;
            vault_open    <= 1'b0;
            active_phase  <= '0;
            attempts_left <= ATT_MAX;
          end
        end
        LOCKOUT: begin
          if (tmr_expire) begin
            state         <= IDLE;
            locked_out    <= 1'b0;
            attempts_left <= ATT_MAX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vault_sequencer.sv
// Directed bench for vault_sequencer with short timeout/lockout parameters.
module tb_vault_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       relock = 1'b0;
  logic [2:0] phase_done = '0;
  logic [2:0] phase_fail = '0;
  logic [2:0] phase_rst;
  logic [1:0] active_phase;
  logic       vault_open;
  logic       locked_out;
  logic       fail_pulse;
  logic [1:0] attempts_left;

  int         total = 0;
  int         bad = 0;
  logic [1:0] exp_att = 2'd3;
  logic [9:0] want;

  vault_sequencer #(
    .NUM_PHASES     (3),
    .MAX_ATTEMPTS   (3),
    .PHASE_TIMEOUT  (20),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .relock        (relock),
    .phase_done    (phase_done),
    .phase_fail    (phase_fail),
    .phase_rst     (phase_rst),
    .active_phase  (active_phase),
    .vault_open    (vault_open),
    .locked_out    (locked_out),
    .fail_pulse    (fail_pulse),
    .attempts_left (attempts_left)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] snap();
    return {phase_rst, active_phase, vault_open, locked_out, fail_pulse, attempts_left};
  endfunction

  function automatic logic [9:0] pack(logic [2:0] r, logic [1:0] a, logic o, logic l,
                                      logic f, logic [1:0] at);
    return {r, a, o, l, f, at};
  endfunction

  function automatic logic [2:0] run_rst(int p);
    logic [2:0] one = 3'b001;
    return ~(one << p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_attempt(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    want = pack(3'b111, 2'd0, 1'b0, 1'b0, 1'b0, exp_att);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL %s_arm: got %h want %h", tag, snap(), want); end
    tick();
    want = pack(run_rst(0), 2'd0, 1'b0, 1'b0, 1'b0, exp_att);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL %s_run0: got %h want %h", tag, snap(), want); end
  endtask

  task automatic pass_phase(input int p);
    for (int i = 1; i <= 3; i++) begin
      tick();
      want = pack(run_rst(p), 2'(p), 1'b0, 1'b0, 1'b0, exp_att);
      total++;
      if (snap() !== want) begin bad++; $display("FAIL phase%0d_run_t%0d: got %h want %h", p, i, snap(), want); end
    end
    phase_done[p] = 1'b1;
    tick();
    phase_done[p] = 1'b0;
    if (p < 2) begin
      want = pack(3'b111, 2'(p + 1), 1'b0, 1'b0, 1'b0, exp_att);
      total++;
      if (snap() !== want) begin bad++; $display("FAIL phase%0d_advance_arm: got %h want %h", p, snap(), want); end
      tick();
      want = pack(run_rst(p + 1), 2'(p + 1), 1'b0, 1'b0, 1'b0, exp_att);
      total++;
      if (snap() !== want) begin bad++; $display("FAIL phase%0d_advance_run: got %h want %h", p, snap(), want); end
    end else begin
      want = pack(3'b111, 2'd2, 1'b1, 1'b0, 1'b0, exp_att);
      total++;
      if (snap() !== want) begin bad++; $display("FAIL open_entry: got %h want %h", snap(), want); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    want = pack(3'b111, 2'd0, 1'b0, 1'b0, 1'b0, 2'd3);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL reset_hold: got %h want %h", snap(), want); end
    reset = 1'b0;
    repeat (2) tick();
    total++;
    if (snap() !== want) begin bad++; $display("FAIL reset_idle: got %h want %h", snap(), want); end
  endtask

  task automatic test_happy_path();
    begin_attempt("happy");
    for (int p = 0; p < 3; p++) pass_phase(p);
  endtask

  task automatic test_open_relock();
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    want = pack(3'b111, 2'd2, 1'b1, 1'b0, 1'b0, exp_att);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL open_ignores_start: got %h want %h", snap(), want); end
    relock = 1'b1;
    tick();
    relock = 1'b0;
    exp_att = 2'd3;
    want = pack(3'b111, 2'd0, 1'b0, 1'b0, 1'b0, 2'd3);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL relock_idle: got %h want %h", snap(), want); end
  endtask

  task automatic test_fail_recover();
    begin_attempt("recover1");
    pass_phase(0);
    tick();
    phase_fail[1] = 1'b1;
    tick();
    phase_fail[1] = 1'b0;
    exp_att = 2'd2;
    want = pack(3'b111, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL phase1_fail_pulse: got %h want %h", snap(), want); end
    tick();
    want = pack(3'b111, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL fail_pulse_width: got %h want %h", snap(), want); end
    begin_attempt("recover2");
    for (int p = 0; p < 3; p++) pass_phase(p);
    test_open_relock();
  endtask

  task automatic test_priority();
    begin_attempt("prio");
    phase_done = 3'b110;
    phase_fail = 3'b110;
    for (int i = 1; i <= 3; i++) begin
      tick();
      want = pack(3'b110, 2'd0, 1'b0, 1'b0, 1'b0, exp_att);
      total++;
      if (snap() !== want) begin bad++; $display("FAIL isolation_t%0d: got %h want %h", i, snap(), want); end
    end
    phase_done = 3'b001;
    phase_fail = 3'b001;
    tick();
    phase_done = '0;
    phase_fail = '0;
    exp_att = 2'd2;
    want = pack(3'b111, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL done_and_fail: got %h want %h", snap(), want); end
    tick();
  endtask

  task automatic test_timeout();
    begin_attempt("timeout");
    for (int i = 1; i <= 19; i++) begin
      tick();
      want = pack(3'b110, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2);
      total++;
      if (snap() !== want) begin bad++; $display("FAIL timeout_run_t%0d: got %h want %h", i, snap(), want); end
    end
    tick();
    exp_att = 2'd1;
    want = pack(3'b111, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL timeout_fail: got %h want %h", snap(), want); end
    tick();
    want = pack(3'b111, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL timeout_idle: got %h want %h", snap(), want); end
  endtask

  task automatic test_reset_mid();
    begin_attempt("midreset");
    pass_phase(0);
    tick();
    reset = 1'b1;
    #1;
    exp_att = 2'd3;
    want = pack(3'b111, 2'd0, 1'b0, 1'b0, 1'b0, 2'd3);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL async_reset: got %h want %h", snap(), want); end
    tick();
    reset = 1'b0;
    total++;
    if (snap() !== want) begin bad++; $display("FAIL reset_after_edge: got %h want %h", snap(), want); end
    tick();
  endtask

  task automatic test_lockout();
    for (int k = 0; k < 3; k++) begin
      begin_attempt($sformatf("lock%0d", k));
      phase_fail[0] = 1'b1;
      tick();
      phase_fail[0] = 1'b0;
      exp_att = exp_att - 2'd1;
      want = pack(3'b111, 2'd0, 1'b0, (k == 2), 1'b1, exp_att);
      total++;
      if (snap() !== want) begin bad++; $display("FAIL lock_fail%0d: got %h want %h", k, snap(), want); end
      if (k < 2) tick();
    end
    start = 1'b1;
    relock = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      want = pack(3'b111, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
      total++;
      if (snap() !== want) begin bad++; $display("FAIL lockout_hold_t%0d: got %h want %h", i, snap(), want); end
    end
    start = 1'b0;
    relock = 1'b0;
    tick();
    exp_att = 2'd3;
    want = pack(3'b111, 2'd0, 1'b0, 1'b0, 1'b0, 2'd3);
    total++;
    if (snap() !== want) begin bad++; $display("FAIL lockout_release: got %h want %h", snap(), want); end
    begin_attempt("post_lockout");
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_open_relock();
    test_fail_recover();
    test_priority();
    test_timeout();
    test_reset_mid();
    test_lockout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
